alu_exec_unit: RTL
==================

# alu_exec_unit

Multi-cycle execute unit that consumes the 4-bit ALU control code produced by the ALU decoder and evaluates the operation on two 32-bit operands. It sits in the EX stage of the RV32 pipeline behind a valid/ready handshake. Single-cycle ops complete in one cycle. Shifts run through an iterative one-bit-per-cycle shifter, so EX can stall the pipeline.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be 32 for RV32.
- SHAMT_W, 5, shift amount width taken from SrcB[SHAMT_W-1:0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and control valid.
- in_ready  output  1  unit can accept a new operation.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B / shift amount.
- ALUControl  input  4  operation code from ALU decoder.
- funct7b5  input  1  selects SRA (1) vs SRL (0) when ALUControl=0101.
- out_valid  output  1  Result valid.
- out_ready  input  1  downstream accepts Result.
- Result  output  WIDTH  operation result.
- Zero  output  1  Result == 0.
- Illegal  output  1  ALUControl was not a defined code.

## Operation
- Codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SRL/SRA (by funct7b5), 0110 SLTU, 0111 SLL, 1000 SLT. Codes 1001–1111 are illegal: Result=0, Illegal=1, completes like a single-cycle op.
- ADD/SUB wrap modulo 2^32. SLT is a signed compare and SLTU an unsigned compare. Both give 32'h1 or 32'h0.
- Shift amount = SrcB[4:0]. Upper bits of SrcB are ignored. SRA fills vacated bits with the original SrcA[31].
- State machine:
  - IDLE: in_ready=1. On in_valid, latch the operands, code, funct7b5 and shamt.
    - Non-shift op, or shift with shamt=0: compute, register Result, go to DONE.
    - Shift with shamt>0: load the shift register with SrcA and the counter with shamt, go to SHIFT.
  - SHIFT: each cycle shift by one bit and decrement the counter. When the counter reaches 1, that is the final shift; go to DONE.
  - DONE: out_valid=1. Result, Zero and Illegal are held stable. On out_ready go to IDLE.
- in_ready is 1 only in IDLE. There is no accept in the same cycle as a DONE handoff.
- Inputs other than in_valid are ignored outside IDLE.
- Zero and Illegal are registered together with Result.

## Timing
- Reset values: in_ready=1, out_valid=0, Result=0, Zero=0, Illegal=0, state=IDLE, counter=0.
- Latency is measured from the accept edge (in_valid & in_ready) to the first cycle with out_valid=1:
  - non-shift, illegal, or shamt=0: 1 cycle;
  - shift with shamt=N: 1+N cycles (max 32).
- Throughput: at most one op per 2 cycles. This falls out of the IDLE→DONE→IDLE path.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold and no shifting occurs.
- Reset is asserted mid-SHIFT or mid-DONE: the op is discarded with no output. The next cycle shows the reset values.
- Reset and in_valid in the same cycle: reset wins and nothing is accepted.

## Configuration
- ALU_FAST_SHIFT_EN defined: shifts use a combinational barrel shifter. Every op, including shifts, takes the 1-cycle path and the SHIFT state is not built.
- ALU_FAST_SHIFT_EN not defined: shifts use the iterative path with the latency given above.
- Functional results are identical in both configurations. Only latency differs.

## Test plan
- ADD SrcA=32'hFFFF_FFFF, SrcB=1 → Result=0, Zero=1, out_valid one cycle after accept. SUB 5−7 → 32'hFFFF_FFFE.
- SLT vs SLTU with SrcA=32'h8000_0000, SrcB=1 → SLT Result=1, SLTU Result=0.
- SRA SrcA=32'h8000_00F0, SrcB=32'hFFFF_FFE4 (shamt 4), funct7b5=1 → Result=32'hF800_000F. Iterative build gives out_valid 5 cycles after accept; fast build gives 1.
- Backpressure: SLL SrcA=1, shamt=31, out_ready=0 for 10 cycles → Result=32'h8000_0000 held with out_valid=1 and in_ready=0. Release out_ready → back to IDLE next cycle.
- ALUControl=4'b1011 → Result=0, Illegal=1, Zero=1 after 1 cycle.
- Reset asserted at the 3rd SHIFT cycle of SRL shamt=20 → out_valid never rises, in_ready=1 and Result=0 the following cycle. A new ADD then completes normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   EX-stage execute unit for RV32. Takes the 4-bit ALU control code from the
//   ALU decoder and two operands behind a valid/ready handshake.
//   Single-cycle ops go IDLE -> DONE. In the default build, shifts walk
//   through an iterative one-bit-per-cycle shifter: IDLE -> SHIFT -> DONE.
//
//   Build option: define ALU_FAST_SHIFT_EN to replace the iterative shifter
//   with a combinational barrel shifter. Every op then takes the 1-cycle path
//   and the SHIFT state is never entered.
//
//   Handshake: an op is accepted on a rising edge where in_valid && in_ready.
//   A result is handed off on a rising edge where out_valid && out_ready.
//   in_ready is high only in IDLE and out_valid only in DONE, so accept and
//   handoff never happen on the same edge. Result, Zero and Illegal are
//   registers and hold steady for the whole time out_valid is high.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake
//   SrcA, SrcB        operands (SrcB[SHAMT_W-1:0] is the shift amount)
//   ALUControl        operation code; funct7b5 selects SRA(1)/SRL(0)
//   out_valid/out_ready output handshake
//   Result, Zero, Illegal  registered result and flags
//   dbg_state         current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  input  logic             funct7b5,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Illegal,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SR   = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ill;

  assign shamt = SrcB[SHAMT_W-1:0];

`ifdef ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0] sra_full;
  assign sra_full = $signed(SrcA) >>> shamt;
`else
  // Iterative shifter state. result_q doubles as the shift register while in
  // SHIFT; out_valid is low then, so the partial value is never consumed.
  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         kind_q, kind_d;
  logic               alu_shift;
  logic [1:0]         alu_kind;
  logic [WIDTH-1:0]   shift_step;

  // One-bit step; SRA replicates the sign bit, which is SrcA[31] throughout.
  always_comb begin
    shift_step = {1'b0, result_q[WIDTH-1:1]};
    if (kind_q == K_SLL)      shift_step = {result_q[WIDTH-2:0], 1'b0};
    else if (kind_q == K_SRA) shift_step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
  end
`endif

  // Operation evaluated on the live inputs; only used in IDLE.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
    alu_shift = 1'b0;
    alu_kind  = K_SLL;
`endif
    case (ALUControl)
      OP_ADD:  alu_res = SrcA + SrcB;
      OP_SUB:  alu_res = SrcA - SrcB;
      OP_AND:  alu_res = SrcA & SrcB;
      OP_OR:   alu_res = SrcA | SrcB;
      OP_XOR:  alu_res = SrcA ^ SrcB;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SR:   alu_res = funct7b5 ? sra_full : (SrcA >> shamt);
      OP_SLL:  alu_res = SrcA << shamt;
`else
      // Shift by zero yields SrcA unchanged; nonzero amounts use SHIFT.
      OP_SR: begin
        alu_res   = SrcA;
        alu_shift = 1'b1;
        alu_kind  = funct7b5 ? K_SRA : K_SRL;
      end
      OP_SLL: begin
        alu_res   = SrcA;
        alu_shift = 1'b1;
        alu_kind  = K_SLL;
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
    cnt_d     = cnt_q;
    kind_d    = kind_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
          if (alu_shift && (shamt != '0)) begin
            result_d  = SrcA;
            cnt_d     = shamt;
            kind_d    = alu_kind;
            zero_d    = 1'b0;
            illegal_d = 1'b0;
            state_d   = S_SHIFT;
          end else
`endif
          begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = S_DONE;
          end
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        result_d = shift_step;
        cnt_d    = cnt_q - 1'b1;
        // Counter at 1 means this edge performs the last shift.
        if (cnt_q == SHAMT_W'(1)) begin
          zero_d  = (shift_step == '0);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q     <= '0;
      kind_q    <= K_SLL;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Illegal   = illegal_q;
  assign dbg_state = state_q;

endmodule
